vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the VRAM word address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the VRAM word width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 8, meaning the maximum consecutive cycles a pending CPU request may be denied.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports vga_req in 1, vga_addr in ADDR_W, vga_gnt out 1, vga_rvalid out 1 and vga_rdata out DATA_W: the scanout read-only requester.
REQ-007 The block SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W, cpu_gnt out 1, cpu_rvalid out 1 and cpu_rdata out DATA_W: the CPU read/write requester.
REQ-008 The block SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W and mem_rdata in DATA_W: the single-port synchronous VRAM, with 1-cycle read latency.

Function
REQ-009 Handshake: requester holds req, addr, we and wdata stable until gnt; gnt is a 1-cycle pulse per accepted request; req still high the cycle after gnt is a new request.
REQ-010 At most one of vga_gnt and cpu_gnt SHALL be high in any cycle; gnt is combinational from req and arbiter state.
REQ-011 FSM states: VGA_PRI (reset state, VGA wins on conflict) and CPU_FORCE (CPU wins on conflict).
REQ-012 VGA_PRI -> CPU_FORCE when the starvation counter equals STARVE_LIMIT; CPU_FORCE -> VGA_PRI on the cycle after cpu_gnt.
REQ-013 Starvation counter: increments each cycle cpu_req=1 and cpu_gnt=0; clears on cpu_gnt or when cpu_req=0; saturates at STARVE_LIMIT.
REQ-014 With a single requester active, that requester SHALL be granted in the same cycle regardless of state.
REQ-015 Memory command: grant in cycle N -> mem_en=1 with the winner's addr, we and wdata registered, driven in cycle N+1; mem_we=0 for VGA.
REQ-016 Read return: for a read granted in N, the matching rvalid SHALL be high in N+2 with rdata=mem_rdata; the other rvalid SHALL be 0.
REQ-017 Writes SHALL produce no rvalid; cpu_gnt on a write completes the transaction.
REQ-018 A 2-stage return-tag pipeline (NONE/VGA/CPU) SHALL track in-flight reads; back-to-back grants every cycle SHALL be sustained with no bubbles.
REQ-019 Idle cycles SHALL drive mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
REQ-020 rdata outputs SHALL be zero whenever the corresponding rvalid=0.

Reset
REQ-021 On rst_n=0, asynchronously: state=VGA_PRI, counter=0, tags=NONE, and mem_en, mem_we, mem_addr, mem_wdata, vga_rvalid and cpu_rvalid all 0; vga_gnt and cpu_gnt SHALL be 0 while rst_n=0.
REQ-022 Reads in flight at reset SHALL be dropped: no rvalid for them after rst_n deasserts.
REQ-023 The first grant SHALL be possible in the first cycle with rst_n=1.

Structure
REQ-024 Package lalu_vram_pkg SHALL hold the return-tag typedef (NONE/VGA/CPU), the FSM state typedef, and the defaults for ADDR_W and DATA_W.
REQ-025 One sub-module, vram_tag_pipe (the 2-stage tag delay line with async reset), SHALL be used; arbitration and the starvation counter stay in vram_arbiter.

Verification
REQ-026 VGA-only read, vga_addr=0x0010, RAM[0x0010]=0xDEADBEEF -> vga_gnt in N, mem_en/mem_addr=0x0010 in N+1, vga_rvalid with vga_rdata=0xDEADBEEF in N+2.
REQ-027 CPU write 0x1234 to 0x0020, then CPU read of 0x0020 -> mem_we=1 on the first command only; cpu_rvalid with cpu_rdata=0x00001234 two cycles after the second cpu_gnt.
REQ-028 vga_req and cpu_req both held high continuously, STARVE_LIMIT=8 -> vga_gnt for 8 cycles, then cpu_gnt for exactly 1 cycle, repeating; never both gnt high.
REQ-029 Alternating VGA read and CPU read every cycle at addresses 0..15 -> 16 consecutive mem_en cycles; each rvalid goes to the correct requester with the correct data.
REQ-030 rst_n pulsed low in the cycle after a VGA read grant -> outputs 0 immediately; no vga_rvalid after release; a new request is granted on the first cycle after release.

Source files
------------

// File: rtl/lalu_vram_pkg.sv
// Shared types and defaults for the VRAM arbiter slice.
//   ret_tag_e   : owner of a read in flight through the return pipeline
//   arb_state_e : arbiter priority state
//   ADDR_W_DEF / DATA_W_DEF : default VRAM address and word widths
package lalu_vram_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_CPU  = 2'd2
  } ret_tag_e;

  typedef enum logic {
    VGA_PRI   = 1'b0,
    CPU_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vram_tag_pipe.sv
// Two-stage delay line for return tags.
//   clk, rst_n : clock, asynchronous active-low reset (clears to TAG_NONE)
//   tag_in     : tag of the read granted this cycle (TAG_NONE if none)
//   tag_out    : tag of the read whose data is on mem_rdata this cycle
module vram_tag_pipe
  import lalu_vram_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  ret_tag_e tag_in,
  output ret_tag_e tag_out
);

  ret_tag_e s1_q, s1_d;
  ret_tag_e s2_q, s2_d;

  always_comb begin
    s1_d = tag_in;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= TAG_NONE;
      s2_q <= TAG_NONE;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign tag_out = s2_q;

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester arbiter for a single-port synchronous VRAM (1-cycle read
// latency). VGA scanout normally wins conflicts; a pending CPU request that
// has been denied STARVE_LIMIT cycles in a row is forced through next.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   vga_req/addr, vga_gnt       : scanout read request and grant pulse
//   vga_rvalid/rdata            : scanout read return (2 cycles after grant)
//   cpu_req/we/addr/wdata, gnt  : CPU read/write request and grant pulse
//   cpu_rvalid/rdata            : CPU read return (2 cycles after grant)
//   mem_en/we/addr/wdata/rdata  : registered VRAM command, read data in
module vram_arbiter
  import lalu_vram_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              vga_gnt_c, cpu_gnt_c;
  ret_tag_e          tag_in, tag_out;

  // Grants are combinational and held low while reset is asserted.
  always_comb begin
    vga_gnt_c = 1'b0;
    cpu_gnt_c = 1'b0;
    if (rst_n) begin
      if (vga_req && cpu_req) begin
        if (state_q == CPU_FORCE) cpu_gnt_c = 1'b1;
        else                      vga_gnt_c = 1'b1;
      end else begin
        vga_gnt_c = vga_req;
        cpu_gnt_c = cpu_req;
      end
    end
  end

  // The force decision uses the next counter value so that the CPU wins on
  // the cycle right after its STARVE_LIMIT-th consecutive denial.
  always_comb begin
    starve_cnt_d = '0;
    if (cpu_req && !cpu_gnt_c) begin
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q
                                               : starve_cnt_q + CNT_W'(1);
    end

    state_d = state_q;
    case (state_q)
      VGA_PRI:   if (starve_cnt_d == CNT_MAX) state_d = CPU_FORCE;
      CPU_FORCE: if (cpu_gnt_c)               state_d = VGA_PRI;
      default:                                state_d = VGA_PRI;
    endcase
  end

  // Memory command for the winner; address and write data hold when idle.
  always_comb begin
    mem_en_d    = vga_gnt_c | cpu_gnt_c;
    mem_we_d    = cpu_gnt_c & cpu_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (cpu_gnt_c) begin
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
    end else if (vga_gnt_c) begin
      mem_addr_d  = vga_addr;
    end

    tag_in = TAG_NONE;
    if (vga_gnt_c)                tag_in = TAG_VGA;
    else if (cpu_gnt_c && !cpu_we) tag_in = TAG_CPU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= VGA_PRI;
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  vram_tag_pipe u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign vga_gnt    = vga_gnt_c;
  assign cpu_gnt    = cpu_gnt_c;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  assign vga_rvalid = (tag_out == TAG_VGA);
  assign cpu_rvalid = (tag_out == TAG_CPU);
  assign vga_rdata  = vga_rvalid ? mem_rdata : '0;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_req, cpu_req, cpu_we;
  logic [15:0] vga_addr, cpu_addr;
  logic [31:0] cpu_wdata;
  logic        vga_gnt, vga_rvalid, cpu_gnt, cpu_rvalid;
  logic [31:0] vga_rdata, cpu_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  // Behavioural VRAM with a side preload port.
  logic [31:0] ram [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  vram_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic idle_inputs();
    vga_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vga_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    vga_addr = 16'h0001; cpu_addr = 16'h0002; cpu_wdata = 32'h0;
    #1;
    checks++; if (vga_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin errors++;
      $display("FAIL reset_gnt got vga=%b cpu=%b want 0 0", vga_gnt, cpu_gnt); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++;
      $display("FAIL reset_mem_ctl got en=%b we=%b want 0 0", mem_en, mem_we); end
    checks++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin errors++;
      $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
    checks++; if (vga_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || vga_rdata !== 32'h0 || cpu_rdata !== 32'h0) begin errors++;
      $display("FAIL reset_rvalid got %b %b %h %h want 0 0 0 0", vga_rvalid, cpu_rvalid, vga_rdata, cpu_rdata); end
    idle_inputs();
    // Preload RAM while reset is held.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); pre_we = 1'b1; pre_addr = 8'(i); pre_data = 32'hA500_0000 | 32'(i);
    end
    @(negedge clk); pre_addr = 8'h10; pre_data = 32'hDEAD_BEEF;
    @(negedge clk); pre_addr = 8'h30; pre_data = 32'hC0FF_EE30;
    @(negedge clk); pre_we = 1'b0; rst_n = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++;
      $display("FAIL reset_release_mem_en got %b want 0", mem_en); end
  endtask

  task automatic test_vga_read();
    @(negedge clk); vga_req = 1'b1; vga_addr = 16'h0010; #1;
    checks++; if (vga_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin errors++;
      $display("FAIL vga_read_gnt got vga=%b cpu=%b want 1 0", vga_gnt, cpu_gnt); end
    @(negedge clk); vga_req = 1'b0; #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin errors++;
      $display("FAIL vga_read_cmd got en=%b we=%b addr=%h want 1 0 0010", mem_en, mem_we, mem_addr); end
    checks++; if (vga_rvalid !== 1'b0) begin errors++;
      $display("FAIL vga_read_early got rvalid=%b want 0", vga_rvalid); end
    @(negedge clk); #1;
    checks++; if (vga_rvalid !== 1'b1 || vga_rdata !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL vga_read_data got rvalid=%b rdata=%h want 1 deadbeef", vga_rvalid, vga_rdata); end
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin errors++;
      $display("FAIL vga_read_cpu_quiet got %b %h want 0 0", cpu_rvalid, cpu_rdata); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin errors++;
      $display("FAIL vga_read_idle got en=%b we=%b addr=%h want 0 0 0010", mem_en, mem_we, mem_addr); end
    @(negedge clk); #1;
    checks++; if (vga_rvalid !== 1'b0 || vga_rdata !== 32'h0) begin errors++;
      $display("FAIL vga_read_after got rvalid=%b rdata=%h want 0 0", vga_rvalid, vga_rdata); end
  endtask

  task automatic test_cpu_write_read();
    @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 32'h0000_1234; #1;
    checks++; if (cpu_gnt !== 1'b1 || vga_gnt !== 1'b0) begin errors++;
      $display("FAIL cpu_wr_gnt got cpu=%b vga=%b want 1 0", cpu_gnt, vga_gnt); end
    @(negedge clk); cpu_we = 1'b0; cpu_wdata = 32'hFFFF_FFFF; #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++;
      $display("FAIL cpu_rd_gnt got %b want 1", cpu_gnt); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 32'h0000_1234) begin errors++;
      $display("FAIL cpu_wr_cmd got en=%b we=%b addr=%h wdata=%h want 1 1 0020 00001234", mem_en, mem_we, mem_addr, mem_wdata); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0020) begin errors++;
      $display("FAIL cpu_rd_cmd got en=%b we=%b addr=%h want 1 0 0020", mem_en, mem_we, mem_addr); end
    checks++; if (cpu_rvalid !== 1'b0 || vga_rvalid !== 1'b0) begin errors++;
      $display("FAIL cpu_wr_no_rvalid got cpu=%b vga=%b want 0 0", cpu_rvalid, vga_rvalid); end
    @(negedge clk); #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0000_1234) begin errors++;
      $display("FAIL cpu_rd_data got rvalid=%b rdata=%h want 1 00001234", cpu_rvalid, cpu_rdata); end
    checks++; if (vga_rvalid !== 1'b0) begin errors++;
      $display("FAIL cpu_rd_vga_quiet got %b want 0", vga_rvalid); end
  endtask

  task automatic test_starvation();
    logic exp_vga;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      vga_req = 1'b1; vga_addr = 16'h0001;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
      #1;
      exp_vga = ((k % 9) < 8);
      checks++; if (vga_gnt !== exp_vga || cpu_gnt !== !exp_vga) begin errors++;
        $display("FAIL starve_cycle%0d got vga=%b cpu=%b want %b %b", k, vga_gnt, cpu_gnt, exp_vga, !exp_vga); end
    end
    @(negedge clk); idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i < 16) begin
        if (i % 2 == 0) begin vga_req = 1'b1; vga_addr = 16'(i); end
        else begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'(i); end
      end
      #1;
      if (i < 16) begin
        checks++; if (vga_gnt !== (i % 2 == 0) || cpu_gnt !== (i % 2 == 1)) begin errors++;
          $display("FAIL b2b_gnt%0d got vga=%b cpu=%b", i, vga_gnt, cpu_gnt); end
      end
      if (i >= 1 && i <= 16) begin
        checks++; if (mem_en !== 1'b1 || mem_addr !== 16'(i - 1)) begin errors++;
          $display("FAIL b2b_cmd%0d got en=%b addr=%h want 1 %h", i, mem_en, mem_addr, 16'(i - 1)); end
      end
      if (i >= 2) begin
        exp_data = 32'hA500_0000 | 32'(i - 2);
        if ((i - 2) % 2 == 0) begin
          checks++; if (vga_rvalid !== 1'b1 || vga_rdata !== exp_data || cpu_rvalid !== 1'b0) begin errors++;
            $display("FAIL b2b_vga_ret%0d got v=%b d=%h c=%b want 1 %h 0", i, vga_rvalid, vga_rdata, cpu_rvalid, exp_data); end
        end else begin
          checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp_data || vga_rvalid !== 1'b0) begin errors++;
            $display("FAIL b2b_cpu_ret%0d got c=%b d=%h v=%b want 1 %h 0", i, cpu_rvalid, cpu_rdata, vga_rvalid, exp_data); end
        end
      end
    end
    @(negedge clk); #1;
    checks++; if (mem_en !== 1'b0 || vga_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++;
      $display("FAIL b2b_drain got en=%b v=%b c=%b want 0 0 0", mem_en, vga_rvalid, cpu_rvalid); end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk); vga_req = 1'b1; vga_addr = 16'h0010; #1;
    checks++; if (vga_gnt !== 1'b1) begin errors++;
      $display("FAIL rst_fly_gnt got %b want 1", vga_gnt); end
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (mem_en !== 1'b0 || mem_addr !== 16'h0 || vga_gnt !== 1'b0) begin errors++;
      $display("FAIL rst_fly_async got en=%b addr=%h gnt=%b want 0 0000 0", mem_en, mem_addr, vga_gnt); end
    @(negedge clk); rst_n = 1'b1; vga_addr = 16'h0030; #1;
    checks++; if (vga_rvalid !== 1'b0 || vga_rdata !== 32'h0) begin errors++;
      $display("FAIL rst_fly_dropped got rvalid=%b rdata=%h want 0 0", vga_rvalid, vga_rdata); end
    checks++; if (vga_gnt !== 1'b1) begin errors++;
      $display("FAIL rst_fly_first_gnt got %b want 1", vga_gnt); end
    @(negedge clk); vga_req = 1'b0; #1;
    checks++; if (vga_rvalid !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 16'h0030) begin errors++;
      $display("FAIL rst_fly_cmd got rvalid=%b en=%b addr=%h want 0 1 0030", vga_rvalid, mem_en, mem_addr); end
    @(negedge clk); #1;
    checks++; if (vga_rvalid !== 1'b1 || vga_rdata !== 32'hC0FF_EE30) begin errors++;
      $display("FAIL rst_fly_new_data got rvalid=%b rdata=%h want 1 c0ffee30", vga_rvalid, vga_rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vga_read();
    test_cpu_write_read();
    test_starvation();
    test_back_to_back();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
